// File: rtl/usb_rx_ctrl_if.sv
// Bundles the decoded-bit-stream inputs and the RX FIFO-facing outputs of usb_rx_ctrl.
// master drives the line-side pulses and data; slave is the receive controller.
// pkt_len exists only when RX_PKT_LEN_EN is defined.
interface usb_rx_ctrl_if;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
`ifdef RX_PKT_LEN_EN
    logic [6:0] pkt_len;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  rcving, w_enable, r_error, pkt_len
    );
    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output rcving, w_enable, r_error, pkt_len
    );
`else
    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  rcving, w_enable, r_error
    );
    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output rcving, w_enable, r_error
    );
`endif
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control: start detect, SYNC check, byte strobes to RX FIFO, EOP close.
// Latency: rcving/w_enable/r_error are registered, one clk after the causing input.
// No backpressure: the FIFO must accept every w_enable; RX_PKT_LEN_EN adds the pkt_len output.
module usb_rx_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic         clk,
    input  logic         rst,
    usb_rx_ctrl_if.slave rx
);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] SYNC_WAIT = 4'd1;
    localparam logic [3:0] SYNC_CHK  = 4'd2;
    localparam logic [3:0] BYTE_WAIT = 4'd3;
    localparam logic [3:0] STORE     = 4'd4;
    localparam logic [3:0] EOP_END   = 4'd5;
    localparam logic [3:0] ERR_EOP   = 4'd6;
    localparam logic [3:0] ERR_EDGE  = 4'd7;
    localparam logic [3:0] EIDLE     = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          rcving_q, rcving_d;
    logic          w_enable_q, w_enable_d;
    logic          r_error_q, r_error_d;
    logic          eop_bit;
    logic          pkt_start;

    // SE0 only counts when seen at a bit-sample point
    assign eop_bit = rx.eop & rx.shift_enable;

    // Packet sequencing; a byte arriving together with EOP is never stored
    always_comb begin
        state_d   = state_q;
        pkt_start = 1'b0;
        case (state_q)
            IDLE, EIDLE: begin
                if (rx.d_edge) begin
                    state_d   = SYNC_WAIT;
                    pkt_start = 1'b1;
                end
            end
            SYNC_WAIT: begin
                if (eop_bit)               state_d = ERR_EOP;
                else if (rx.byte_received) state_d = SYNC_CHK;
            end
            SYNC_CHK: begin
                state_d = (rx.rcv_data == SYNC_BYTE) ? BYTE_WAIT : ERR_EOP;
            end
            BYTE_WAIT: begin
                if (eop_bit) begin
                    state_d = ((bit_cnt_q == 3'd0) && !rx.byte_received) ? EOP_END : ERR_EOP;
                end else if (rx.byte_received) begin
                    state_d = (byte_cnt_q == MAX_CNT) ? ERR_EOP : STORE;
                end
            end
            STORE: begin
                state_d = BYTE_WAIT;
            end
            EOP_END: begin
                if (rx.d_edge) state_d = IDLE;
            end
            ERR_EOP: begin
                if (eop_bit) state_d = ERR_EDGE;
            end
            ERR_EDGE: begin
                if (rx.d_edge) state_d = EIDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit counter tracks position inside the current byte; byte counter tracks stored bytes
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (pkt_start || rx.byte_received) begin
            bit_cnt_d = 3'd0;
        end else if (rx.shift_enable) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        byte_cnt_d = byte_cnt_q;
        if (pkt_start) begin
            byte_cnt_d = '0;
        end else if (state_q == STORE) begin
            byte_cnt_d = byte_cnt_q + CW'(1);
        end
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        rcving_d   = !(state_d inside {IDLE, EIDLE});
        w_enable_d = (state_d == STORE);
        r_error_d  = (state_d inside {ERR_EOP, ERR_EDGE, EIDLE});
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            rcving_q   <= 1'b0;
            w_enable_q <= 1'b0;
            r_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rcving_q   <= rcving_d;
            w_enable_q <= w_enable_d;
            r_error_q  <= r_error_d;
        end
    end

    assign rx.rcving   = rcving_q;
    assign rx.w_enable = w_enable_q;
    assign rx.r_error  = r_error_q;

`ifdef RX_PKT_LEN_EN
    logic [6:0] pkt_len_q, pkt_len_d;

    // Length is published only when a packet closes cleanly
    always_comb begin
        pkt_len_d = pkt_len_q;
        if ((state_q == EOP_END) && (state_d == IDLE)) begin
            pkt_len_d = 7'(byte_cnt_q);
        end
    end

    // Packet length register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_len_q <= 7'd0;
        end else begin
            pkt_len_q <= pkt_len_d;
        end
    end

    assign rx.pkt_len = pkt_len_q;
`endif
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Randomized packet-level bench for usb_rx_ctrl against a transaction-level outcome model.
// Each packet is described by SYNC byte, data bytes and ending kind; the model predicts writes, error and length.
// Outputs are sampled 1 time unit after the rising edge; FIFO writes are captured on the falling edge.
module tb_usb_rx_ctrl;
    localparam int         MAXB = 4;
    localparam logic [7:0] SYNC = 8'h80;
    localparam int K_CLEAN   = 0;
    localparam int K_EARLY   = 1;
    localparam int K_SIMUL   = 2;
    localparam int K_SYNCEOP = 3;

    logic clk = 1'b0;
    logic rst;

    usb_rx_ctrl_if bus ();

    usb_rx_ctrl #(.SYNC_BYTE(SYNC), .MAX_BYTES(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    string      cur_pkt = "init";
    logic [7:0] got_q[$];
    logic [7:0] pd[$];
    logic       prev_we = 1'b0;
    int         exp_len = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_pkt, tag, got, exp);
        end
    endtask

    // FIFO-side monitor: collects written bytes, flags back-to-back strobes
    always @(negedge clk) begin
        if (bus.w_enable) begin
            got_q.push_back(bus.rcv_data);
            chk("we_back_to_back", int'(prev_we), 0);
        end
        prev_we = bus.w_enable;
    end

    task automatic cyc(input logic e, input logic se, input logic br, input logic eo);
        bus.d_edge        = e;
        bus.shift_enable  = se;
        bus.byte_received = br;
        bus.eop           = eo;
        @(posedge clk);
        #1;
        bus.d_edge        = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.eop           = 1'b0;
    endtask

    // n bit periods: sample pulse then a gap cycle, gap may carry a stray D+ edge
    task automatic bits(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(noise && ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noise, input int exp_we);
        bits(8, noise);
        bus.rcv_data = b;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("we_latency", int'(bus.w_enable), exp_we);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One packet on the line, then compare outcome with the model
    task automatic run_pkt(input string nm, input logic [7:0] sync_b, input int kind, input int early_bits);
        int stored;
        bit err;
        bit sync_ok;
        sync_ok = (kind != K_SYNCEOP) && (sync_b == SYNC);
        if (!sync_ok) begin
            stored = 0;
            err    = 1'b1;
        end else begin
            stored = (pd.size() > MAXB) ? MAXB : pd.size();
            err    = (pd.size() > MAXB) || (kind != K_CLEAN);
        end
        cur_pkt = nm;
        got_q.delete();

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rcving_start", int'(bus.rcving), 1);
        chk("rerr_start", int'(bus.r_error), 0);

        if (kind == K_SYNCEOP) begin
            bits(early_bits, 1'b1);
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
        end else begin
            send_byte(sync_b, 1'b1, 0);
            for (int i = 0; i < pd.size(); i++) begin
                send_byte(pd[i], 1'b1, (sync_ok && i < MAXB) ? 1 : 0);
            end
            if (kind == K_CLEAN) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b1);
            end else if (kind == K_EARLY) begin
                bits(early_bits, 1'b1);
                cyc(1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
                bits(8, 1'b1);
                bus.rcv_data = 8'($urandom);
                cyc(1'b0, 1'b1, 1'b1, 1'b1);
            end
        end
        // SE0 lasts two bit times, then the line returns to J
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        chk("write_count", got_q.size(), stored);
        for (int i = 0; i < stored && i < got_q.size(); i++) begin
            chk("write_data", int'(got_q[i]), int'(pd[i]));
        end
        chk("rerr_end", int'(bus.r_error), err ? 1 : 0);
        chk("rcving_end", int'(bus.rcving), 0);
        if (!err) exp_len = stored;
`ifdef RX_PKT_LEN_EN
        chk("pkt_len", int'(bus.pkt_len), exp_len);
`endif
    endtask

    initial begin
        int n;
        int k;
        logic [7:0] sb;

        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_data      = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cur_pkt = "reset";
        chk("rcving", int'(bus.rcving), 0);
        chk("w_enable", int'(bus.w_enable), 0);
        chk("r_error", int'(bus.r_error), 0);
`ifdef RX_PKT_LEN_EN
        chk("pkt_len", int'(bus.pkt_len), 0);
`endif
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted between clock edges in the middle of a data byte
        cur_pkt = "mid_reset";
        got_q.delete();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'h11, 1'b0, 1);
        bits(3, 1'b0);
        chk("rcving_pre", int'(bus.rcving), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rcving", int'(bus.rcving), 0);
        chk("w_enable", int'(bus.w_enable), 0);
        chk("r_error", int'(bus.r_error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_len = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("writes", got_q.size(), 1);

        pd = '{8'hA5, 8'h3C};
        run_pkt("good", SYNC, K_CLEAN, 0);
        pd = '{8'h12};
        run_pkt("bad_sync", 8'h81, K_CLEAN, 0);
        pd = '{8'h5A};
        run_pkt("after_bad", SYNC, K_CLEAN, 0);
        pd = '{8'hC3};
        run_pkt("early_eop", SYNC, K_EARLY, 3);
        pd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_pkt("overflow", SYNC, K_CLEAN, 0);
        pd = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_pkt("exact_max", SYNC, K_CLEAN, 0);
        pd = '{8'h77};
        run_pkt("simul", SYNC, K_SIMUL, 0);
        pd.delete();
        run_pkt("empty", SYNC, K_CLEAN, 0);
        run_pkt("eop_in_sync", SYNC, K_SYNCEOP, 4);

        for (int p = 0; p < 40; p++) begin
            pd.delete();
            n = $urandom_range(0, MAXB + 2);
            for (int i = 0; i < n; i++) pd.push_back(8'($urandom));
            sb = ($urandom_range(0, 4) == 0) ? 8'($urandom) : SYNC;
            k  = $urandom_range(0, 5);
            run_pkt("random", sb, (k > 3) ? K_CLEAN : k, $urandom_range(1, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
